// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the F/M memory port arbiter.
// State encodings and the issue-selection helper used by the top.
// No logic of its own.
package mem_port_arbiter_pkg;

  // Arbiter FSM states: one request phase and one wait phase per requester.
  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_F_REQ  = 3'd1,
    ARB_F_WAIT = 3'd2,
    ARB_D_REQ  = 3'd3,
    ARB_D_WAIT = 3'd4
  } arb_state_e;

  // Which requester (if any) is granted the memory in an IDLE cycle.
  typedef enum logic [1:0] {
    ISSUE_NONE  = 2'd0,
    ISSUE_FETCH = 2'd1,
    ISSUE_DATA  = 2'd2
  } issue_e;

  // Data access always wins over fetch; the M stage is older in the pipe.
  function automatic issue_e pick_issue(input logic dm_pending,
                                        input logic fetch_pending);
    issue_e sel;
    if (dm_pending) begin
      sel = ISSUE_DATA;
    end else if (fetch_pending) begin
      sel = ISSUE_FETCH;
    end else begin
      sel = ISSUE_NONE;
    end
    return sel;
  endfunction

  // States in which the memory request line is asserted.
  function automatic logic is_req_state(input arb_state_e s);
    return (s == ARB_F_REQ) || (s == ARB_D_REQ);
  endfunction

  // States that belong to a fetch transaction (kill applies to these).
  function automatic logic is_fetch_state(input arb_state_e s);
    return (s == ARB_F_REQ) || (s == ARB_F_WAIT);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Latency: issue cycle, ack cycle(s), rvalid cycle; result visible the cycle after rvalid.
// Backpressure: one transaction outstanding; requesters stall via stall_f/stall_m until served.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // fetch side
  input  logic                  i_if_req,
  input  logic [ADDR_W-1:0]     i_if_addr,
  input  logic                  i_if_take,
  input  logic                  i_if_kill,
  output logic                  o_if_valid,
  output logic [DATA_W-1:0]     o_if_rdata,
  // data side
  input  logic                  i_dm_req,
  input  logic                  i_dm_we,
  input  logic [ADDR_W-1:0]     i_dm_addr,
  input  logic [DATA_W-1:0]     i_dm_wdata,
  input  logic [DATA_W/8-1:0]   i_dm_be,
  output logic                  o_dm_valid,
  output logic [DATA_W-1:0]     o_dm_rdata,
  // hazard unit
  output logic                  o_stall_f,
  output logic                  o_stall_m,
  // memory side
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_be,
  input  logic                  i_mem_ack,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_W-1:0]     i_mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  issue_e              w_issue;

  logic                w_dm_pending;
  logic                w_f_pending;
  logic                w_f_rsp;
  logic                w_d_rsp;
  logic                w_f_done;
  logic                w_kill_hit;

  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [BE_W-1:0]     r_mem_be;

  logic                r_if_valid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic                r_dm_valid;
  logic [DATA_W-1:0]   r_dm_rdata;
  logic                r_kill_pending;

  // A data request is still owed service unless it is completing this very
  // cycle (dm_valid high means the M stage's current request is the one done).
  assign w_dm_pending = i_dm_req && !r_dm_valid;
  // A fetch is owed only if the buffer is empty and the PC is not being redirected.
  assign w_f_pending  = i_if_req && !r_if_valid && !i_if_kill;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the grant decision is only taken in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = ISSUE_NONE;
    unique case (r_state)
      ARB_IDLE: begin
        w_issue = pick_issue(w_dm_pending, w_f_pending);
        if (w_issue == ISSUE_DATA) begin
          w_state_nxt = ARB_D_REQ;
        end else if (w_issue == ISSUE_FETCH) begin
          w_state_nxt = ARB_F_REQ;
        end
      end
      ARB_F_REQ:  if (i_mem_ack)    w_state_nxt = ARB_F_WAIT;
      ARB_F_WAIT: if (i_mem_rvalid) w_state_nxt = ARB_IDLE;
      ARB_D_REQ:  if (i_mem_ack)    w_state_nxt = ARB_D_WAIT;
      ARB_D_WAIT: if (i_mem_rvalid) w_state_nxt = ARB_IDLE;
      default:                      w_state_nxt = ARB_IDLE;
    endcase
  end

  // FSM outputs: request line and response qualification (rvalid outside a
  // wait state is not ours and is dropped here).
  always_comb begin
    o_mem_req = is_req_state(r_state);
    w_f_rsp   = 1'b0;
    w_d_rsp   = 1'b0;
    case (r_state)
      ARB_F_WAIT: w_f_rsp = i_mem_rvalid;
      ARB_D_WAIT: w_d_rsp = i_mem_rvalid;
      default: ;
    endcase
  end

  // A kill arriving together with the response also discards it.
  assign w_f_done   = w_f_rsp && !r_kill_pending && !i_if_kill;
  assign w_kill_hit = i_if_kill && is_fetch_state(r_state);

  // Request fields are captured at grant time so they stay stable until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      case (w_issue)
        ISSUE_DATA: begin
          r_mem_we    <= i_dm_we;
          r_mem_addr  <= i_dm_addr;
          r_mem_wdata <= i_dm_wdata;
          r_mem_be    <= i_dm_be;
        end
        ISSUE_FETCH: begin
          r_mem_we    <= 1'b0;
          r_mem_addr  <= i_if_addr;
          r_mem_wdata <= '0;
          r_mem_be    <= '1;
        end
        default: ;
      endcase
    end
  end

  // Remember that the in-flight fetch was killed; its response is thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kill_pending <= 1'b0;
    end else if (w_f_rsp) begin
      r_kill_pending <= 1'b0;
    end else if (w_kill_hit) begin
      r_kill_pending <= 1'b1;
    end
  end

  // One-entry fetch buffer; a new word arriving beats a simultaneous take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid <= 1'b0;
      r_if_rdata <= '0;
    end else if (w_f_done) begin
      r_if_valid <= 1'b1;
      r_if_rdata <= i_mem_rdata;
    end else if (i_if_take || i_if_kill) begin
      r_if_valid <= 1'b0;
    end
  end

  // Data completion: one-cycle pulse, read data held until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dm_valid <= 1'b0;
      r_dm_rdata <= '0;
    end else begin
      r_dm_valid <= w_d_rsp;
      if (w_d_rsp) begin
        r_dm_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_be    = r_mem_be;
  assign o_if_valid  = r_if_valid;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_valid  = r_dm_valid;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_stall_f   = i_if_req && !r_if_valid;
  assign o_stall_m   = i_dm_req && !r_dm_valid;

  // Request fields must not move while the memory has not yet accepted them.
  property p_req_stable;
    @(posedge clk) disable iff (!rst_n)
      (o_mem_req && !i_mem_ack) |=>
        (o_mem_req && $stable(o_mem_addr) && $stable(o_mem_we) &&
         $stable(o_mem_wdata) && $stable(o_mem_be));
  endproperty
  a_req_stable: assert property (p_req_stable);

  // dm_valid is a single-cycle pulse.
  property p_dm_pulse;
    @(posedge clk) disable iff (!rst_n) o_dm_valid |=> !o_dm_valid;
  endproperty
  a_dm_pulse: assert property (p_dm_pulse);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus corner sequences.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
// Memory handshakes are driven directly by the vectors/sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req, if_take, if_kill;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        stall_f, stall_m;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_take(if_take), .i_if_kill(if_kill),
    .o_if_valid(if_valid), .o_if_rdata(if_rdata),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .i_dm_be(dm_be), .o_dm_valid(dm_valid), .o_dm_rdata(dm_rdata),
    .o_stall_f(stall_f), .o_stall_m(stall_m),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
    .i_mem_ack(mem_ack), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        if_req;  logic [31:0] if_addr; logic if_take; logic if_kill;
    logic        dm_req;  logic dm_we; logic [31:0] dm_addr; logic [3:0] dm_be;
    logic        ack;     logic rv;    logic [31:0] rdata;
    logic        e_req;   logic e_we;  logic [31:0] e_addr; logic [3:0] e_be;
    logic        e_ifv;   logic [31:0] e_ifd;
    logic        e_dmv;   logic [31:0] e_dmd;
    logic        e_sf;    logic e_sm;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic quiet();
    if_req = 1'b0; if_addr = 32'h0; if_take = 1'b0; if_kill = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_be = 4'h0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // if_req addr take kill | dm_req we addr be | ack rv rdata || req we addr be | ifv ifd | dmv dmd | sf sm
    // fetch 0x100, acked at once, data one cycle later
    vecs[0]  = '{1'b1,32'h100,1'b0,1'b0, 1'b0,1'b0,32'h0,4'h0, 1'b0,1'b0,32'h0,
                 1'b0,1'b0,32'h0,4'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b1,1'b0};
    vecs[1]  = '{1'b1,32'h100,1'b0,1'b0, 1'b0,1'b0,32'h0,4'h0, 1'b1,1'b0,32'h0,
                 1'b1,1'b0,32'h100,4'hF, 1'b0,32'h0, 1'b0,32'h0, 1'b1,1'b0};
    vecs[2]  = '{1'b1,32'h100,1'b0,1'b0, 1'b0,1'b0,32'h0,4'h0, 1'b0,1'b1,32'h13,
                 1'b0,1'b0,32'h100,4'hF, 1'b0,32'h0, 1'b0,32'h0, 1'b1,1'b0};
    vecs[3]  = '{1'b1,32'h100,1'b1,1'b0, 1'b0,1'b0,32'h0,4'h0, 1'b0,1'b0,32'h0,
                 1'b0,1'b0,32'h100,4'hF, 1'b1,32'h13, 1'b0,32'h0, 1'b0,1'b0};
    // load 0x200 and fetch 0x104 together: data first
    vecs[4]  = '{1'b1,32'h104,1'b0,1'b0, 1'b1,1'b0,32'h200,4'hF, 1'b0,1'b0,32'h0,
                 1'b0,1'b0,32'h100,4'hF, 1'b0,32'h13, 1'b0,32'h0, 1'b1,1'b1};
    vecs[5]  = '{1'b1,32'h104,1'b0,1'b0, 1'b1,1'b0,32'h200,4'hF, 1'b1,1'b0,32'h0,
                 1'b1,1'b0,32'h200,4'hF, 1'b0,32'h13, 1'b0,32'h0, 1'b1,1'b1};
    vecs[6]  = '{1'b1,32'h104,1'b0,1'b0, 1'b1,1'b0,32'h200,4'hF, 1'b0,1'b1,32'hDEADBEEF,
                 1'b0,1'b0,32'h200,4'hF, 1'b0,32'h13, 1'b0,32'h0, 1'b1,1'b1};
    vecs[7]  = '{1'b1,32'h104,1'b0,1'b0, 1'b1,1'b0,32'h200,4'hF, 1'b0,1'b0,32'h0,
                 1'b0,1'b0,32'h200,4'hF, 1'b0,32'h13, 1'b1,32'hDEADBEEF, 1'b1,1'b0};
    vecs[8]  = '{1'b1,32'h104,1'b0,1'b0, 1'b0,1'b0,32'h0,4'h0, 1'b1,1'b0,32'h0,
                 1'b1,1'b0,32'h104,4'hF, 1'b0,32'h13, 1'b0,32'hDEADBEEF, 1'b1,1'b0};
    vecs[9]  = '{1'b1,32'h104,1'b0,1'b0, 1'b0,1'b0,32'h0,4'h0, 1'b0,1'b1,32'h00400093,
                 1'b0,1'b0,32'h104,4'hF, 1'b0,32'h13, 1'b0,32'hDEADBEEF, 1'b1,1'b0};
    vecs[10] = '{1'b1,32'h104,1'b1,1'b0, 1'b0,1'b0,32'h0,4'h0, 1'b0,1'b0,32'h0,
                 1'b0,1'b0,32'h104,4'hF, 1'b1,32'h00400093, 1'b0,32'hDEADBEEF, 1'b0,1'b0};
    vecs[11] = '{1'b0,32'h108,1'b0,1'b0, 1'b0,1'b0,32'h0,4'h0, 1'b0,1'b0,32'h0,
                 1'b0,1'b0,32'h104,4'hF, 1'b0,32'h00400093, 1'b0,32'hDEADBEEF, 1'b0,1'b0};
    // stray rvalid while idle must change nothing
    vecs[12] = '{1'b0,32'h108,1'b0,1'b0, 1'b0,1'b0,32'h0,4'h0, 1'b0,1'b1,32'h77,
                 1'b0,1'b0,32'h104,4'hF, 1'b0,32'h00400093, 1'b0,32'hDEADBEEF, 1'b0,1'b0};
    vecs[13] = '{1'b0,32'h108,1'b0,1'b0, 1'b0,1'b0,32'h0,4'h0, 1'b0,1'b0,32'h0,
                 1'b0,1'b0,32'h104,4'hF, 1'b0,32'h00400093, 1'b0,32'hDEADBEEF, 1'b0,1'b0};

    // ---- reset state ----
    quiet();
    repeat (2) @(negedge clk);
    #1;
    chk1 ("rst.mem_req",   mem_req,   1'b0);
    chk1 ("rst.mem_we",    mem_we,    1'b0);
    chk32("rst.mem_addr",  mem_addr,  32'h0);
    chk32("rst.mem_wdata", mem_wdata, 32'h0);
    chk32("rst.mem_be",    {28'h0, mem_be}, 32'h0);
    chk1 ("rst.if_valid",  if_valid,  1'b0);
    chk32("rst.if_rdata",  if_rdata,  32'h0);
    chk1 ("rst.dm_valid",  dm_valid,  1'b0);
    chk32("rst.dm_rdata",  dm_rdata,  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      if_take = vecs[i].if_take; if_kill = vecs[i].if_kill;
      dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we;
      dm_addr = vecs[i].dm_addr; dm_be = vecs[i].dm_be; dm_wdata = 32'h0;
      mem_ack = vecs[i].ack; mem_rvalid = vecs[i].rv; mem_rdata = vecs[i].rdata;
      #1;
      chk1 ($sformatf("v%0d.mem_req", i),  mem_req,  vecs[i].e_req);
      chk1 ($sformatf("v%0d.mem_we", i),   mem_we,   vecs[i].e_we);
      chk32($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].e_addr);
      chk32($sformatf("v%0d.mem_be", i),   {28'h0, mem_be}, {28'h0, vecs[i].e_be});
      chk1 ($sformatf("v%0d.if_valid", i), if_valid, vecs[i].e_ifv);
      chk32($sformatf("v%0d.if_rdata", i), if_rdata, vecs[i].e_ifd);
      chk1 ($sformatf("v%0d.dm_valid", i), dm_valid, vecs[i].e_dmv);
      chk32($sformatf("v%0d.dm_rdata", i), dm_rdata, vecs[i].e_dmd);
      chk1 ($sformatf("v%0d.stall_f", i),  stall_f,  vecs[i].e_sf);
      chk1 ($sformatf("v%0d.stall_m", i),  stall_m,  vecs[i].e_sm);
    end

    // ---- store, ack delayed 3 cycles ----
    @(negedge clk);
    quiet();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'hCAFEF00D; dm_be = 4'b0011;
    #1;
    chk1("st0.mem_req", mem_req, 1'b0);
    chk1("st0.stall_m", stall_m, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      mem_ack = (c == 4);
      #1;
      chk1 ($sformatf("st%0d.mem_req", c),   mem_req,   1'b1);
      chk1 ($sformatf("st%0d.mem_we", c),    mem_we,    1'b1);
      chk32($sformatf("st%0d.mem_addr", c),  mem_addr,  32'h300);
      chk32($sformatf("st%0d.mem_wdata", c), mem_wdata, 32'hCAFEF00D);
      chk32($sformatf("st%0d.mem_be", c),    {28'h0, mem_be}, 32'h3);
      chk1 ($sformatf("st%0d.stall_m", c),   stall_m,   1'b1);
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
    #1;
    chk1("st5.mem_req", mem_req, 1'b0);
    chk1("st5.stall_m", stall_m, 1'b1);
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    chk1 ("st6.dm_valid", dm_valid, 1'b1);
    chk32("st6.dm_rdata", dm_rdata, 32'h5A5A5A5A);
    chk1 ("st6.stall_m",  stall_m,  1'b0);
    @(negedge clk);
    dm_req = 1'b0;
    #1;
    chk1("st7.dm_valid", dm_valid, 1'b0);
    chk1("st7.no_reissue", mem_req, 1'b0);

    // ---- fetch killed in F_WAIT, then redirected fetch to 0x400 ----
    @(negedge clk);
    quiet();
    if_req = 1'b1; if_addr = 32'h180;
    #1;
    chk1("k0.stall_f", stall_f, 1'b1);
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    chk32("k1.mem_addr", mem_addr, 32'h180);
    chk1 ("k1.mem_req",  mem_req,  1'b1);
    @(negedge clk);
    mem_ack = 1'b0; if_kill = 1'b1;
    #1;
    chk1("k2.if_valid", if_valid, 1'b0);
    @(negedge clk);
    if_kill = 1'b0; if_addr = 32'h400; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    #1;
    chk1("k3.mem_req", mem_req, 1'b0);
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    chk1 ("k4.if_valid_discarded", if_valid, 1'b0);
    chk32("k4.if_rdata_kept",      if_rdata, 32'h00400093);
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    chk1 ("k5.mem_req",  mem_req,  1'b1);
    chk32("k5.mem_addr", mem_addr, 32'h400);
    @(negedge clk);
    mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00000011;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    chk1 ("k7.if_valid", if_valid, 1'b1);
    chk32("k7.if_rdata", if_rdata, 32'h00000011);

    // ---- full buffer holds off further fetches until taken ----
    if_addr = 32'h404;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      chk1($sformatf("hold%0d.mem_req", c),  mem_req,  1'b0);
      chk1($sformatf("hold%0d.if_valid", c), if_valid, 1'b1);
      chk1($sformatf("hold%0d.stall_f", c),  stall_f,  1'b0);
    end
    @(negedge clk);
    if_take = 1'b1;
    #1;
    chk1("take0.if_valid", if_valid, 1'b1);
    chk1("take0.mem_req",  mem_req,  1'b0);
    @(negedge clk);
    if_take = 1'b0;
    #1;
    chk1("take1.if_valid", if_valid, 1'b0);
    chk1("take1.mem_req",  mem_req,  1'b0);
    chk1("take1.stall_f",  stall_f,  1'b1);
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    chk1 ("take2.mem_req",  mem_req,  1'b1);
    chk32("take2.mem_addr", mem_addr, 32'h404);
    @(negedge clk);
    mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00000513;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'h0; if_req = 1'b0; if_kill = 1'b1;
    #1;
    chk1 ("take4.if_valid", if_valid, 1'b1);
    chk32("take4.if_rdata", if_rdata, 32'h00000513);
    @(negedge clk);
    if_kill = 1'b0;
    #1;
    chk1("kill_buf.if_valid", if_valid, 1'b0);

    // ---- reset during D_WAIT, then a stray rvalid ----
    @(negedge clk);
    quiet();
    dm_req = 1'b1; dm_addr = 32'h500; dm_wdata = 32'h1234; dm_be = 4'hF;
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    chk1 ("rs1.mem_req",  mem_req,  1'b1);
    chk32("rs1.mem_addr", mem_addr, 32'h500);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk1("rs2.mem_req", mem_req, 1'b0);
    chk1("rs2.stall_m", stall_m, 1'b1);
    #1;
    rst_n = 1'b0; dm_req = 1'b0;
    #1;
    chk1 ("rs.mem_req",   mem_req,   1'b0);
    chk32("rs.mem_addr",  mem_addr,  32'h0);
    chk32("rs.mem_wdata", mem_wdata, 32'h0);
    chk32("rs.mem_be",    {28'h0, mem_be}, 32'h0);
    chk32("rs.if_rdata",  if_rdata,  32'h0);
    chk32("rs.dm_rdata",  dm_rdata,  32'h0);
    chk1 ("rs.stall_m",   stall_m,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF;
    #1;
    chk1("rs3.mem_req", mem_req, 1'b0);
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    chk1 ("rs4.dm_valid", dm_valid, 1'b0);
    chk32("rs4.dm_rdata", dm_rdata, 32'h0);
    chk1 ("rs4.if_valid", if_valid, 1'b0);
    chk1 ("rs4.mem_req",  mem_req,  1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (F stage) and data access (M stage) of the 5-stage pipeline.
- Serialises at most one outstanding memory transaction. Data requests take priority. A fetched word is held in a one-entry buffer until the F stage consumes it.
- Outputs stall_f and stall_m, which the hazard unit ORs into its stallF/stallD/flushE terms.
- Accepts a fetch kill from the control-hazard (speculative flush) path and discards in-flight fetch responses.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width (byte enables are DATA_W/8 bits)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  F stage wants the instruction at if_addr
- if_addr  in  ADDR_W  fetch address (PC)
- if_take  in  1  F->D advance this cycle; consumes the buffered word
- if_kill  in  1  redirect/flush; drop buffer and any in-flight fetch
- if_valid  out  1  fetch buffer holds a valid word
- if_rdata  out  DATA_W  buffered instruction
- dm_req  in  1  M stage load/store present
- dm_we  in  1  1=store
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_be  in  DATA_W/8  byte enables
- dm_valid  out  1  one-cycle pulse: data access complete
- dm_rdata  out  DATA_W  load data, valid with dm_valid
- stall_f  out  1  if_req && !if_valid
- stall_m  out  1  dm_req && !dm_valid
- mem_req  out  1  memory request, held until mem_ack
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered request fields, stable while mem_req=1
- mem_ack  in  1  request accepted this cycle
- mem_rvalid  in  1  response (read data or write completion); arrives at least 1 cycle after mem_ack
- mem_rdata  in  DATA_W  read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE. mem_req=0, all mem_* fields=0. if_valid=0, if_rdata=0, dm_valid=0, dm_rdata=0, kill_pending=0.
- FSM states:
  - IDLE: issue is decided on this cycle's inputs.
    - dm_req && !dm_valid -> D_REQ (latch dm fields).
    - else if_req && !if_valid && !if_kill -> F_REQ (latch if_addr, we=0, be=all 1s).
  - F_REQ / D_REQ: mem_req=1. On mem_ack -> F_WAIT / D_WAIT; mem_req=0 next cycle.
  - F_WAIT / D_WAIT: on mem_rvalid -> IDLE.
- Minimum transaction: issue cycle, ack cycle, rvalid cycle. Earliest next issue is the cycle after rvalid.
- Data completion:
  - On mem_rvalid in D_WAIT: dm_valid=1 for exactly one cycle next clock; dm_rdata=mem_rdata (held until the next completion).
  - In the cycle dm_valid=1, IDLE must not re-issue dm_req; that cycle's request is the completed one.
- Fetch completion:
  - On mem_rvalid in F_WAIT with kill_pending=0: if_valid<=1, if_rdata<=mem_rdata.
  - if_valid is cleared by if_take or if_kill.
  - If if_take and a new fetch completion coincide, the completion wins (if_valid stays 1).
- Kill:
  - if_kill in F_REQ/F_WAIT sets kill_pending. The transaction still completes on the memory side; its response is discarded.
  - kill_pending clears on that rvalid.
  - if_kill never affects D_* states.
- Priority: a data request waits for an in-flight fetch to finish; no preemption. A fetch waits for any pending data request.
- Only one transaction is outstanding. mem_rvalid outside *_WAIT is ignored.
- Stores use the same path; dm_rdata is undefined for stores (drive mem_rdata through unchanged).
- Reset mid-transaction: returns to IDLE immediately. Stray mem_rvalid after reset is ignored.

Decomposition:
- consts.v: add state encodings ARB_IDLE, ARB_F_REQ, ARB_F_WAIT, ARB_D_REQ, ARB_D_WAIT (3-bit).
- Single module; no sub-module is needed. The fetch buffer is two registers inline.

Test Plan:
- Fetch only, memory acks at once and rvalid 1 cycle later, if_addr=0x100, rdata=0x00000013 -> mem_req for 1 cycle; if_valid=1 with if_rdata=0x13 on cycle 3; stall_f high cycles 0-2, then low.
- Load 0x200 and fetch 0x104 asserted together -> data issued first, dm_valid pulse with dm_rdata=0xDEADBEEF; fetch issues the cycle after rvalid; no duplicate data issue.
- Store we=1, be=4'b0011 to 0x300 with mem_ack delayed 3 cycles -> mem_req and fields stable for 4 cycles; stall_m=1 until the dm_valid pulse.
- Fetch in F_WAIT, if_kill pulsed -> rvalid arrives, if_valid stays 0; next fetch (new PC 0x400) issues and completes normally.
- if_valid=1 with if_req held and no if_take for 5 cycles -> no new mem_req; if_take -> buffer clears and next fetch issues.
- rst_n low during D_WAIT, then a stray mem_rvalid -> all outputs 0, state IDLE, no dm_valid.
